calc_entry_controller: RTL and testbench

- Sequences operand entry and ALU execution for the 8-bit push-button calculator.
- Debounces and edge-detects the raw Enter/Clear buttons.
- Steps through operand A, operand B and operation entry; drives the ALU inputs, captures the result and flags one cycle later, and drives the progress LEDs.
- Sits between the board switches/buttons and the ALU8 / BCD display path; replaces ad-hoc button latching with one clocked FSM.

---
 rtl/calc_entry_controller_if.sv | 33 +++
 rtl/calc_entry_controller.sv | 137 +++++++++++++
 tb/tb_calc_entry_controller.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_entry_controller_if.sv
// Board-side bundle for the calculator entry controller: buttons, switches,
// the ALU handshake and the display/LED outputs.
interface calc_entry_controller_if;
    logic        enter_btn;
    logic        clear_btn;
    logic [11:0] switches;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_zero;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic [3:0]  alu_op;
    logic [7:0]  result;
    logic [2:0]  result_flags;
    logic        result_valid;
    logic [3:0]  leds;
    logic [2:0]  state_dbg;

    modport master (
        input  enter_btn, clear_btn, switches,
        input  alu_result, alu_carry, alu_overflow, alu_zero,
        output operand_a, operand_b, alu_op, result, result_flags,
        output result_valid, leds, state_dbg
    );

    modport slave (
        output enter_btn, clear_btn, switches,
        output alu_result, alu_carry, alu_overflow, alu_zero,
        input  operand_a, operand_b, alu_op, result, result_flags,
        input  result_valid, leds, state_dbg
    );
endinterface

// File: rtl/calc_entry_controller.sv
// Push-button calculator sequencer: debounces Enter/Clear, collects A, B and op,
// runs the ALU for one cycle and holds the result for chaining.
//
// state  | meaning
// IDLE   | waiting for operand A
// GOT_A  | A latched, waiting for operand B
// GOT_B  | B latched, waiting for the operation code
// EXEC   | one cycle: capture ALU result and flags
// RESULT | result shown; Enter chains it into A
module calc_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic              clock,
    input  logic              reset,
    calc_entry_controller_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_A  = 3'd1,
        GOT_B  = 3'd2,
        EXEC   = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 is Enter, index 1 is Clear.
    logic [1:0]       raw;
    logic [1:0]       sync1, sync2, level, level_d, pulse, armed;
    logic [1:0]       primed;
    logic [CNT_W-1:0] cnt [2];

    assign raw = {bus.clear_btn, bus.enter_btn};

    // A button is only armed once it has been seen released after reset, so a
    // button held across reset cannot produce a pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            pulse   <= '0;
            armed   <= '0;
            primed  <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            primed  <= {primed[0], 1'b1};
            level_d <= level;
            pulse   <= level & ~level_d;
            for (int i = 0; i < 2; i++) begin
                if (primed[1] && !sync2[i]) armed[i] <= 1'b1;
                if (!armed[i] || (sync2[i] == level[i])) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    state_t     state;
    logic [7:0] op_a, op_b, res;
    logic [3:0] op_code, leds_q;
    logic [2:0] flags;
    logic       valid;

    always_ff @(posedge clock) begin
        if (reset || pulse[1]) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            op_code <= '0;
            res     <= '0;
            flags   <= '0;
            valid   <= 1'b0;
            leds_q  <= 4'b0001;
        end else begin
            case (state)
                IDLE: if (pulse[0]) begin
                    op_a   <= bus.switches[7:0];
                    state  <= GOT_A;
                    leds_q <= 4'b0011;
                end
                GOT_A: if (pulse[0]) begin
                    op_b   <= bus.switches[7:0];
                    state  <= GOT_B;
                    leds_q <= 4'b0111;
                end
                GOT_B: if (pulse[0]) begin
                    op_code <= bus.switches[11:8];
                    state   <= EXEC;
                end
                EXEC: begin
                    res    <= bus.alu_result;
                    flags  <= {bus.alu_overflow, bus.alu_carry, bus.alu_zero};
                    valid  <= 1'b1;
                    state  <= RESULT;
                    leds_q <= 4'b1111;
                end
                RESULT: if (pulse[0]) begin
                    op_a    <= res;
                    op_b    <= '0;
                    op_code <= '0;
                    valid   <= 1'b0;
                    state   <= GOT_A;
                    leds_q  <= 4'b0011;
                end
                default: begin
                    state   <= IDLE;
                    op_a    <= '0;
                    op_b    <= '0;
                    op_code <= '0;
                    res     <= '0;
                    flags   <= '0;
                    valid   <= 1'b0;
                    leds_q  <= 4'b0001;
                end
            endcase
        end
    end

    assign bus.operand_a    = op_a;
    assign bus.operand_b    = op_b;
    assign bus.alu_op       = op_code;
    assign bus.result       = res;
    assign bus.result_flags = flags;
    assign bus.result_valid = valid;
    assign bus.leds         = leds_q;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_calc_entry_controller.sv
// Bench for calc_entry_controller: directed scenarios plus random button
// sequences checked against a behavioural calculator model.
module tb_calc_entry_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    calc_entry_controller_if bus();

    calc_entry_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // ALU stub: returns {overflow, carry, zero, result}.
    function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] op);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        w = '0;
        case (op)
            4'h0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            default: begin
                r = a ^ b ^ {op, op};
                c = 1'b0;
                v = 1'b0;
            end
        endcase
        return {v, c, (r == 8'h00), r};
    endfunction

    always_comb {bus.alu_overflow, bus.alu_carry, bus.alu_zero, bus.alu_result} =
        alu_model(bus.operand_a, bus.operand_b, bus.alu_op);

    // Calculator model: how many entries of the current calculation are in,
    // and whether a result is on display.
    logic [7:0] m_a, m_b, m_res;
    logic [3:0] m_op;
    logic [2:0] m_flags;
    bit         m_valid, m_have;
    int         m_entries;

    function automatic void model_clear();
        m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_flags = '0;
        m_valid = 0; m_have = 0; m_entries = 0;
    endfunction

    function automatic void model_enter(input logic [11:0] sw);
        logic [11:0] alu;
        if (m_have) begin
            m_a = m_res; m_b = '0; m_op = '0; m_valid = 0; m_have = 0; m_entries = 1;
        end else if (m_entries == 0) begin
            m_a = sw[7:0]; m_entries = 1;
        end else if (m_entries == 1) begin
            m_b = sw[7:0]; m_entries = 2;
        end else begin
            m_op = sw[11:8];
            alu = alu_model(m_a, m_b, m_op);
            m_res = alu[7:0]; m_flags = alu[11:9];
            m_valid = 1; m_have = 1; m_entries = 0;
        end
    endfunction

    function automatic logic [2:0] exp_state();
        return m_have ? 3'd4 : 3'(m_entries);
    endfunction

    function automatic logic [3:0] exp_leds();
        if (m_have) return 4'b1111;
        case (m_entries)
            0: return 4'b0001;
            1: return 4'b0011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_clear();
        repeat (4) @(negedge clock);
    endtask

    task automatic press(input bit en, input bit cl, input logic [11:0] sw, input int hold);
        @(negedge clock);
        bus.switches  = sw;
        bus.enter_btn = en;
        bus.clear_btn = cl;
        repeat (hold) @(negedge clock);
        bus.enter_btn = 1'b0;
        bus.clear_btn = 1'b0;
        repeat (14) @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
        checks++; if (bus.leds !== 4'b0001) begin failures++; $display("FAIL reset_leds got=%b exp=0001", bus.leds); end
        checks++; if ({bus.operand_a, bus.operand_b, bus.alu_op, bus.result, bus.result_flags, bus.result_valid} !== 32'h0)
            begin failures++; $display("FAIL reset_regs got a=%h b=%h op=%h r=%h f=%b v=%b exp all zero",
                bus.operand_a, bus.operand_b, bus.alu_op, bus.result, bus.result_flags, bus.result_valid); end
    endtask

    task automatic test_enter_latency();
        @(negedge clock);
        bus.switches  = 12'h00C;
        bus.enter_btn = 1'b1;
        repeat (7) @(posedge clock);
        #1;
        checks++; if (bus.state_dbg !== 3'd0) begin failures++; $display("FAIL latency_early got=%0d exp=0", bus.state_dbg); end
        @(posedge clock);
        #1;
        checks++; if (bus.state_dbg !== 3'd1) begin failures++; $display("FAIL latency_edge got=%0d exp=1", bus.state_dbg); end
        repeat (12) @(negedge clock);
        bus.enter_btn = 1'b0;
        repeat (14) @(negedge clock);
        model_enter(12'h00C);
        checks++; if (bus.state_dbg !== 3'd1) begin failures++; $display("FAIL held_one_pulse got=%0d exp=1", bus.state_dbg); end
        checks++; if (bus.operand_a !== 8'h0C) begin failures++; $display("FAIL held_operand_a got=%h exp=0c", bus.operand_a); end
        checks++; if (bus.leds !== 4'b0011) begin failures++; $display("FAIL held_leds got=%b exp=0011", bus.leds); end
    endtask

    task automatic test_full_sequence();
        bit found;
        press(1'b1, 1'b0, 12'h005, 10);
        model_enter(12'h005);
        checks++; if (bus.state_dbg !== 3'd2) begin failures++; $display("FAIL seq_got_b got=%0d exp=2", bus.state_dbg); end
        checks++; if (bus.operand_b !== 8'h05) begin failures++; $display("FAIL seq_operand_b got=%h exp=05", bus.operand_b); end
        checks++; if (bus.leds !== 4'b0111) begin failures++; $display("FAIL seq_leds_b got=%b exp=0111", bus.leds); end
        @(negedge clock);
        bus.switches  = 12'h000;
        bus.enter_btn = 1'b1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.state_dbg === 3'd3) begin found = 1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL seq_exec_reached got=timeout exp=state 3"); end
        @(negedge clock);
        checks++; if (bus.state_dbg !== 3'd4) begin failures++; $display("FAIL seq_exec_one_cycle got=%0d exp=4", bus.state_dbg); end
        bus.enter_btn = 1'b0;
        repeat (14) @(negedge clock);
        model_enter(12'h000);
        checks++; if (bus.result !== 8'h11) begin failures++; $display("FAIL seq_result got=%h exp=11", bus.result); end
        checks++; if (bus.result_valid !== 1'b1) begin failures++; $display("FAIL seq_valid got=%b exp=1", bus.result_valid); end
        checks++; if (bus.leds !== 4'b1111) begin failures++; $display("FAIL seq_leds got=%b exp=1111", bus.leds); end
        checks++; if (bus.result_flags !== 3'b000) begin failures++; $display("FAIL seq_flags got=%b exp=000", bus.result_flags); end
    endtask

    task automatic test_chain();
        logic [11:0] sw;
        sw = 12'($urandom);
        press(1'b1, 1'b0, sw, 10);
        model_enter(sw);
        checks++; if (bus.operand_a !== 8'h11) begin failures++; $display("FAIL chain_a got=%h exp=11", bus.operand_a); end
        checks++; if ({bus.operand_b, bus.alu_op} !== 12'h000) begin failures++; $display("FAIL chain_b_op got=%h/%h exp=0/0", bus.operand_b, bus.alu_op); end
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL chain_valid got=%b exp=0", bus.result_valid); end
        checks++; if (bus.state_dbg !== 3'd1 || bus.leds !== 4'b0011) begin failures++; $display("FAIL chain_state got=%0d/%b exp=1/0011", bus.state_dbg, bus.leds); end
        checks++; if (bus.result !== 8'h11) begin failures++; $display("FAIL chain_result_hold got=%h exp=11", bus.result); end
    endtask

    task automatic test_carry();
        press(1'b0, 1'b1, 12'h000, 10);
        model_clear();
        press(1'b1, 1'b0, 12'h0FF, 10); model_enter(12'h0FF);
        press(1'b1, 1'b0, 12'h001, 10); model_enter(12'h001);
        press(1'b1, 1'b0, 12'h000, 10); model_enter(12'h000);
        checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL carry_result got=%h exp=00", bus.result); end
        checks++; if (bus.result_flags !== 3'b011) begin failures++; $display("FAIL carry_flags got=%b exp=011", bus.result_flags); end
    endtask

    task automatic test_clear_with_enter();
        press(1'b1, 1'b0, 12'h000, 10); model_enter(12'h000);
        press(1'b1, 1'b0, 12'h0A5, 10); model_enter(12'h0A5);
        checks++; if (bus.state_dbg !== 3'd2) begin failures++; $display("FAIL clr_setup got=%0d exp=2", bus.state_dbg); end
        press(1'b1, 1'b1, 12'hF3C, 10);
        model_clear();
        checks++; if (bus.state_dbg !== 3'd0 || bus.leds !== 4'b0001) begin failures++; $display("FAIL clr_state got=%0d/%b exp=0/0001", bus.state_dbg, bus.leds); end
        checks++; if ({bus.operand_a, bus.operand_b, bus.alu_op, bus.result, bus.result_flags, bus.result_valid} !== 32'h0)
            begin failures++; $display("FAIL clr_regs got a=%h b=%h op=%h r=%h f=%b v=%b exp all zero",
                bus.operand_a, bus.operand_b, bus.alu_op, bus.result, bus.result_flags, bus.result_valid); end
        repeat (20) @(negedge clock);
        checks++; if (bus.state_dbg !== 3'd0) begin failures++; $display("FAIL clr_no_deferred got=%0d exp=0", bus.state_dbg); end
    endtask

    task automatic test_glitch();
        press(1'b1, 1'b0, 12'h0AB, 10); model_enter(12'h0AB);
        @(negedge clock);
        bus.switches  = 12'h0CD;
        bus.enter_btn = 1'b1;
        repeat (2) @(negedge clock);
        bus.enter_btn = 1'b0;
        repeat (14) @(negedge clock);
        checks++; if (bus.state_dbg !== exp_state()) begin failures++; $display("FAIL glitch_state got=%0d exp=%0d", bus.state_dbg, exp_state()); end
        checks++; if (bus.operand_b !== m_b) begin failures++; $display("FAIL glitch_operand_b got=%h exp=%h", bus.operand_b, m_b); end
    endtask

    task automatic test_reset_exec();
        bit found;
        press(1'b1, 1'b0, 12'h033, 10); model_enter(12'h033);
        @(negedge clock);
        bus.switches  = 12'h123;
        bus.enter_btn = 1'b1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.state_dbg === 3'd3) begin found = 1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL rst_exec_reached got=timeout exp=state 3"); end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (bus.state_dbg !== 3'd0 || bus.leds !== 4'b0001) begin failures++; $display("FAIL rst_exec_state got=%0d/%b exp=0/0001", bus.state_dbg, bus.leds); end
        checks++; if (bus.result_valid !== 1'b0 || bus.operand_a !== 8'h00) begin failures++; $display("FAIL rst_exec_regs got v=%b a=%h exp=0/00", bus.result_valid, bus.operand_a); end
        @(negedge clock);
        reset = 1'b0;
        bus.enter_btn = 1'b0;
        model_clear();
        repeat (14) @(negedge clock);
    endtask

    task automatic test_held_through_reset();
        @(negedge clock);
        bus.switches  = 12'h055;
        bus.enter_btn = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_clear();
        repeat (20) @(negedge clock);
        checks++; if (bus.state_dbg !== 3'd0) begin failures++; $display("FAIL held_reset_no_pulse got=%0d exp=0", bus.state_dbg); end
        bus.enter_btn = 1'b0;
        repeat (14) @(negedge clock);
        press(1'b1, 1'b0, 12'h077, 10); model_enter(12'h077);
        checks++; if (bus.state_dbg !== 3'd1 || bus.operand_a !== 8'h77) begin failures++; $display("FAIL held_reset_repress got=%0d/%h exp=1/77", bus.state_dbg, bus.operand_a); end
    endtask

    task automatic test_random();
        int          act;
        logic [11:0] sw;
        for (int n = 0; n < 30; n++) begin
            act = int'($urandom_range(0, 9));
            sw  = 12'($urandom);
            if (act == 0) begin
                press(1'b0, 1'b1, sw, int'($urandom_range(8, 14)));
                model_clear();
            end else if (act == 1) begin
                press(1'b1, 1'b0, sw, 2);
            end else begin
                press(1'b1, 1'b0, sw, int'($urandom_range(8, 14)));
                model_enter(sw);
            end
            checks++; if (bus.state_dbg !== exp_state() || bus.leds !== exp_leds())
                begin failures++; $display("FAIL rand_state it=%0d got=%0d/%b exp=%0d/%b", n, bus.state_dbg, bus.leds, exp_state(), exp_leds()); end
            checks++; if (bus.operand_a !== m_a || bus.operand_b !== m_b || bus.alu_op !== m_op)
                begin failures++; $display("FAIL rand_operands it=%0d got=%h/%h/%h exp=%h/%h/%h", n, bus.operand_a, bus.operand_b, bus.alu_op, m_a, m_b, m_op); end
            checks++; if (bus.result !== m_res || bus.result_flags !== m_flags || bus.result_valid !== m_valid)
                begin failures++; $display("FAIL rand_result it=%0d got=%h/%b/%b exp=%h/%b/%b", n, bus.result, bus.result_flags, bus.result_valid, m_res, m_flags, m_valid); end
        end
    endtask

    initial begin
        bus.enter_btn = 1'b0;
        bus.clear_btn = 1'b0;
        bus.switches  = 12'h000;
        model_clear();
        test_reset();
        test_enter_latency();
        test_full_sequence();
        test_chain();
        test_carry();
        test_clear_with_enter();
        test_glitch();
        test_reset_exec();
        test_held_through_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=bench completion");
        $fatal(1, "watchdog expired");
    end
endmodule
